// File: rtl/mem_fwd_hazard_unit.sv
// Data-hazard unit beside ID: tracks in-flight register writers, raises load-use
// stalls, and produces EX operand and MEM store-data forward selects.
module mem_fwd_hazard_unit #(
  parameter int REG_AW   = 5,
  parameter int DEPTH    = 3,
  parameter int LOAD_LAT = 1,
  parameter int SELW     = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_use_rs,
  input  logic              id_use_rt,
  input  logic              id_is_store,
  input  logic              id_reg_write,
  input  logic              id_mem2reg,
  input  logic [REG_AW-1:0] id_rd,
  output logic              stall,
  output logic [SELW-1:0]   fwd_a_sel,
  output logic [SELW-1:0]   fwd_b_sel,
  output logic [SELW-1:0]   st_fwd_sel,
  output logic [15:0]       stall_count
);

  // Handshake with ID: id_valid qualifies every id_* field in the same cycle,
  // and stall is the not-ready back to ID; an instruction leaves ID on a cycle
  // with id_valid=1 and stall=0, otherwise a bubble enters the scoreboard.

  localparam int NENT = DEPTH - 1;
  localparam logic [SELW-1:0] LAT_S   = SELW'(LOAD_LAT);
  localparam logic [SELW-1:0] ST_LIM  = SELW'(DEPTH - 2);
  localparam logic [SELW-1:0] DEPTH_S = SELW'(DEPTH);

  // Entry s describes the writer s stages ahead of ID.
  logic [NENT:1]     sb_valid;
  logic [NENT:1]     sb_load;
  logic [REG_AW-1:0] sb_rd [1:NENT];

  logic              a_hit, b_hit, a_ld, b_ld;
  logic [SELW-1:0]   a_dist, b_dist;
  logic              stall_a, stall_b;
  logic [SELW-1:0]   sel_a, sel_b, sel_st;
  logic [SELW-1:0]   st_sel_ex;

  // Scan oldest to youngest so the youngest matching writer is left standing.
  always_comb begin
    a_hit  = 1'b0;
    a_ld   = 1'b0;
    a_dist = '0;
    b_hit  = 1'b0;
    b_ld   = 1'b0;
    b_dist = '0;
    for (int s = NENT; s >= 1; s--) begin
      if (sb_valid[s] && (sb_rd[s] == id_rs)) begin
        a_hit  = 1'b1;
        a_ld   = sb_load[s];
        a_dist = SELW'(s);
      end
      if (sb_valid[s] && (sb_rd[s] == id_rt)) begin
        b_hit  = 1'b1;
        b_ld   = sb_load[s];
        b_dist = SELW'(s);
      end
    end
    a_hit = a_hit & id_use_rs & (id_rs != '0);
    b_hit = b_hit & id_use_rt & (id_rt != '0);
  end

  always_comb begin
    stall_a = 1'b0;
    sel_a   = '0;
    if (a_hit) begin
      if (a_ld && (a_dist <= LAT_S)) stall_a = 1'b1;
      else                           sel_a   = a_dist + SELW'(1);
    end

    stall_b = 1'b0;
    sel_b   = '0;
    sel_st  = '0;
    if (b_hit) begin
      if (!id_is_store) begin
        if (b_ld && (b_dist <= LAT_S)) stall_b = 1'b1;
        else                           sel_b   = b_dist + SELW'(1);
      end else if (b_ld && (b_dist < LAT_S)) begin
        stall_b = 1'b1;
      end else if (b_dist <= ST_LIM) begin
        // Store data can wait until MEM, where the writer is two stages further on.
        sel_st = b_dist + SELW'(2);
      end else begin
        // Writer about to leave the tracked window: grab it at EX instead.
        sel_b = DEPTH_S;
      end
    end
  end

  assign stall = id_valid & (stall_a | stall_b);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sb_valid    <= '0;
      sb_load     <= '0;
      for (int i = 1; i <= NENT; i++) sb_rd[i] <= '0;
      fwd_a_sel   <= '0;
      fwd_b_sel   <= '0;
      st_sel_ex   <= '0;
      st_fwd_sel  <= '0;
      stall_count <= '0;
    end else begin
      sb_valid[1] <= id_valid & id_reg_write & (id_rd != '0) & ~stall;
      sb_load[1]  <= id_mem2reg;
      sb_rd[1]    <= id_rd;
      for (int i = 2; i <= NENT; i++) begin
        sb_valid[i] <= sb_valid[i-1];
        sb_load[i]  <= sb_load[i-1];
        sb_rd[i]    <= sb_rd[i-1];
      end

      if (stall || !id_valid) begin
        fwd_a_sel <= '0;
        fwd_b_sel <= '0;
        st_sel_ex <= '0;
      end else begin
        fwd_a_sel <= sel_a;
        fwd_b_sel <= sel_b;
        st_sel_ex <= sel_st;
      end
      st_fwd_sel <= st_sel_ex;

      if (stall && (stall_count != 16'hFFFF)) stall_count <= stall_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_mem_fwd_hazard_unit.sv
// Bench for mem_fwd_hazard_unit: a DEPTH=3/LOAD_LAT=1 and a DEPTH=5/LOAD_LAT=2
// instance share one ID stream and are checked against a history-based model.
module tb_mem_fwd_hazard_unit;

  localparam int AW = 5;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic          id_valid, id_use_rs, id_use_rt, id_is_store, id_reg_write, id_mem2reg;
  logic [AW-1:0] id_rs, id_rt, id_rd;

  logic          stall0, stall1;
  logic [1:0]    fa0, fb0, st0;
  logic [2:0]    fa1, fb1, st1;
  logic [15:0]   cnt0, cnt1;

  mem_fwd_hazard_unit #(.REG_AW(AW), .DEPTH(3), .LOAD_LAT(1)) dut0 (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_is_store(id_is_store),
    .id_reg_write(id_reg_write), .id_mem2reg(id_mem2reg), .id_rd(id_rd),
    .stall(stall0), .fwd_a_sel(fa0), .fwd_b_sel(fb0), .st_fwd_sel(st0),
    .stall_count(cnt0)
  );

  mem_fwd_hazard_unit #(.REG_AW(AW), .DEPTH(5), .LOAD_LAT(2)) dut1 (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_is_store(id_is_store),
    .id_reg_write(id_reg_write), .id_mem2reg(id_mem2reg), .id_rd(id_rd),
    .stall(stall1), .fwd_a_sel(fa1), .fwd_b_sel(fb1), .st_fwd_sel(st1),
    .stall_count(cnt1)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // ---------------- reference model ----------------
  // hist[d][k] is whatever left ID k+1 cycles ago (bubbles included).
  typedef struct packed {
    logic          wr;
    logic [AW-1:0] rd;
    logic          ld;
  } ent_t;

  ent_t hist [2][8];
  int   m_fa [2];
  int   m_fb [2];
  int   m_st_ex [2];
  int   m_st_mem [2];
  int   m_cnt [2];

  logic        obs_stall [2];
  logic [15:0] obs_fa [2], obs_fb [2], obs_st [2], obs_cnt [2];
  logic        exp_stall [2];
  logic [15:0] exp_fa [2], exp_fb [2], exp_st [2], exp_cnt [2];

  function automatic int dep_of(input int d);
    return (d == 0) ? 3 : 5;
  endfunction

  function automatic int lat_of(input int d);
    return (d == 0) ? 1 : 2;
  endfunction

  task automatic model_step(input int d);
    int dep, lat, sa, sb, ea, eb, es;
    logic la, lb, sta, stb;
    dep = dep_of(d);
    lat = lat_of(d);
    sa = 0; sb = 0; la = 1'b0; lb = 1'b0;
    // First hit from the youngest side is the writer that counts.
    for (int s = 1; s <= dep - 1; s++) begin
      if (sa == 0 && id_use_rs && id_rs != 5'd0 && hist[d][s-1].wr && hist[d][s-1].rd == id_rs) begin
        sa = s; la = hist[d][s-1].ld;
      end
      if (sb == 0 && id_use_rt && id_rt != 5'd0 && hist[d][s-1].wr && hist[d][s-1].rd == id_rt) begin
        sb = s; lb = hist[d][s-1].ld;
      end
    end
    sta = 1'b0; stb = 1'b0; ea = 0; eb = 0; es = 0;
    if (sa != 0) begin
      if (la && sa <= lat) sta = 1'b1;
      else                 ea = sa + 1;
    end
    if (sb != 0) begin
      if (!id_is_store) begin
        if (lb && sb <= lat) stb = 1'b1;
        else                 eb = sb + 1;
      end else if (lb && sb < lat) stb = 1'b1;
      else if (sb <= dep - 2)      es = sb + 2;
      else                         eb = dep;
    end
    exp_stall[d] = id_valid & (sta | stb);
    exp_fa[d]    = 16'(m_fa[d]);
    exp_fb[d]    = 16'(m_fb[d]);
    exp_st[d]    = 16'(m_st_mem[d]);
    exp_cnt[d]   = 16'(m_cnt[d]);

    if (!rst_n) begin
      for (int i = 0; i < 8; i++) hist[d][i] = '0;
      m_fa[d] = 0; m_fb[d] = 0; m_st_ex[d] = 0; m_st_mem[d] = 0; m_cnt[d] = 0;
    end else begin
      for (int i = 7; i >= 1; i--) hist[d][i] = hist[d][i-1];
      hist[d][0].wr = id_valid & id_reg_write & (id_rd != 5'd0) & ~exp_stall[d];
      hist[d][0].rd = id_rd;
      hist[d][0].ld = id_mem2reg;
      m_st_mem[d] = m_st_ex[d];
      if (exp_stall[d] || !id_valid) begin
        m_fa[d] = 0; m_fb[d] = 0; m_st_ex[d] = 0;
      end else begin
        m_fa[d] = ea; m_fb[d] = eb; m_st_ex[d] = es;
      end
      if (exp_stall[d] && m_cnt[d] < 65535) m_cnt[d] = m_cnt[d] + 1;
    end
  endtask

  // One cycle: sample outputs mid-cycle, let the model predict, cross the edge.
  task automatic tick();
    @(negedge clk);
    obs_stall[0] = stall0;    obs_stall[1] = stall1;
    obs_fa[0] = 16'(fa0);     obs_fa[1] = 16'(fa1);
    obs_fb[0] = 16'(fb0);     obs_fb[1] = 16'(fb1);
    obs_st[0] = 16'(st0);     obs_st[1] = 16'(st1);
    obs_cnt[0] = cnt0;        obs_cnt[1] = cnt1;
    model_step(0);
    model_step(1);
    @(posedge clk);
    #1;
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_ins(input logic v, input logic st, input logic wr, input logic ld,
                         input logic urs, input logic urt,
                         input logic [AW-1:0] rs, input logic [AW-1:0] rt, input logic [AW-1:0] rd);
    id_valid = v; id_is_store = st; id_reg_write = wr; id_mem2reg = ld;
    id_use_rs = urs; id_use_rt = urt; id_rs = rs; id_rt = rt; id_rd = rd;
  endtask

  task automatic ins_nop();
    set_ins(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
  endtask

  task automatic ins_lw(input logic [AW-1:0] rd);
    set_ins(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 5'd29, 5'd0, rd);
  endtask

  task automatic ins_sw(input logic [AW-1:0] data, input logic [AW-1:0] base);
    set_ins(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, base, data, 5'd0);
  endtask

  task automatic ins_alu(input logic [AW-1:0] rd, input logic [AW-1:0] rs, input logic [AW-1:0] rt);
    set_ins(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, rs, rt, rd);
  endtask

  task automatic do_reset();
    ins_nop();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    do_reset();
    tick();
    for (int d = 0; d < 2; d++) begin
      n_tests++;
      if (obs_stall[d] !== 1'b0) begin n_fail++; $display("FAIL reset_stall dut%0d: got %b want 0", d, obs_stall[d]); end
      n_tests++;
      if (obs_fa[d] !== 16'd0 || obs_fb[d] !== 16'd0 || obs_st[d] !== 16'd0) begin
        n_fail++; $display("FAIL reset_sel dut%0d: got a=%0d b=%0d st=%0d want 0/0/0", d, obs_fa[d], obs_fb[d], obs_st[d]);
      end
      n_tests++;
      if (obs_cnt[d] !== 16'd0) begin n_fail++; $display("FAIL reset_cnt dut%0d: got %0d want 0", d, obs_cnt[d]); end
    end
  endtask

  task automatic test_lw_sw_d3();
    do_reset();
    ins_lw(5'd8);         tick();
    ins_sw(5'd8, 5'd9);   tick();
    n_tests++;
    if (obs_stall[0] !== 1'b0) begin n_fail++; $display("FAIL lw_sw_d3_stall: got %b want 0", obs_stall[0]); end
    ins_nop();            tick();
    n_tests++;
    if (obs_fb[0] !== 16'd0) begin n_fail++; $display("FAIL lw_sw_d3_fwd_b: got %0d want 0", obs_fb[0]); end
    tick();
    n_tests++;
    if (obs_st[0] !== 16'd3) begin n_fail++; $display("FAIL lw_sw_d3_st_sel: got %0d want 3", obs_st[0]); end
  endtask

  task automatic test_load_use_d3();
    do_reset();
    ins_lw(5'd8);                    tick();
    ins_alu(5'd10, 5'd8, 5'd9);      tick();
    n_tests++;
    if (obs_stall[0] !== 1'b1) begin n_fail++; $display("FAIL load_use_d3_stall1: got %b want 1", obs_stall[0]); end
    tick();
    n_tests++;
    if (obs_stall[0] !== 1'b0) begin n_fail++; $display("FAIL load_use_d3_stall2: got %b want 0", obs_stall[0]); end
    ins_nop();                       tick();
    n_tests++;
    if (obs_fa[0] !== 16'd3) begin n_fail++; $display("FAIL load_use_d3_fwd_a: got %0d want 3", obs_fa[0]); end
    n_tests++;
    if (obs_cnt[0] !== 16'd1) begin n_fail++; $display("FAIL load_use_d3_cnt: got %0d want 1", obs_cnt[0]); end
  endtask

  task automatic test_alu_fwd();
    do_reset();
    ins_alu(5'd8, 5'd1, 5'd2);       tick();
    ins_alu(5'd11, 5'd9, 5'd8);      tick();
    n_tests++;
    if (obs_stall[0] !== 1'b0) begin n_fail++; $display("FAIL alu_fwd_stall: got %b want 0", obs_stall[0]); end
    ins_nop();                       tick();
    n_tests++;
    if (obs_fb[0] !== 16'd2 || obs_fa[0] !== 16'd0) begin
      n_fail++; $display("FAIL alu_fwd_sel: got a=%0d b=%0d want a=0 b=2", obs_fa[0], obs_fb[0]);
    end
  endtask

  task automatic test_youngest();
    do_reset();
    ins_alu(5'd8, 5'd1, 5'd2);       tick();
    ins_alu(5'd8, 5'd3, 5'd4);       tick();
    ins_alu(5'd12, 5'd8, 5'd8);      tick();
    ins_nop();                       tick();
    n_tests++;
    if (obs_fa[0] !== 16'd2 || obs_fb[0] !== 16'd2) begin
      n_fail++; $display("FAIL youngest_d3: got a=%0d b=%0d want 2/2", obs_fa[0], obs_fb[0]);
    end
    n_tests++;
    if (obs_fa[1] !== 16'd2 || obs_fb[1] !== 16'd2) begin
      n_fail++; $display("FAIL youngest_d5: got a=%0d b=%0d want 2/2", obs_fa[1], obs_fb[1]);
    end
  endtask

  task automatic test_reg_zero();
    do_reset();
    ins_lw(5'd0);                    tick();
    ins_alu(5'd5, 5'd0, 5'd0);       tick();
    n_tests++;
    if (obs_stall[0] !== 1'b0 || obs_stall[1] !== 1'b0) begin
      n_fail++; $display("FAIL reg_zero_stall: got %b/%b want 0/0", obs_stall[0], obs_stall[1]);
    end
    ins_nop();                       tick();
    n_tests++;
    if (obs_fa[0] !== 16'd0 || obs_fb[0] !== 16'd0) begin
      n_fail++; $display("FAIL reg_zero_sel: got a=%0d b=%0d want 0/0", obs_fa[0], obs_fb[0]);
    end
  endtask

  task automatic test_reset_mid_stall();
    do_reset();
    ins_lw(5'd8);                    tick();
    ins_alu(5'd10, 5'd8, 5'd9);      tick();
    n_tests++;
    if (obs_stall[0] !== 1'b1) begin n_fail++; $display("FAIL rst_mid_pre_stall: got %b want 1", obs_stall[0]); end
    rst_n = 1'b0;                    tick();
    rst_n = 1'b1;                    tick();
    n_tests++;
    if (obs_stall[0] !== 1'b0) begin n_fail++; $display("FAIL rst_mid_stall: got %b want 0", obs_stall[0]); end
    n_tests++;
    if (obs_fa[0] !== 16'd0 || obs_fb[0] !== 16'd0 || obs_st[0] !== 16'd0 || obs_cnt[0] !== 16'd0) begin
      n_fail++; $display("FAIL rst_mid_outputs: got a=%0d b=%0d st=%0d cnt=%0d want all 0",
                         obs_fa[0], obs_fb[0], obs_st[0], obs_cnt[0]);
    end
  endtask

  task automatic test_d5_load_use();
    do_reset();
    ins_lw(5'd8);                    tick();
    ins_alu(5'd10, 5'd8, 5'd9);      tick();
    n_tests++;
    if (obs_stall[1] !== 1'b1) begin n_fail++; $display("FAIL d5_load_use_stall1: got %b want 1", obs_stall[1]); end
    tick();
    n_tests++;
    if (obs_stall[1] !== 1'b1) begin n_fail++; $display("FAIL d5_load_use_stall2: got %b want 1", obs_stall[1]); end
    tick();
    n_tests++;
    if (obs_stall[1] !== 1'b0) begin n_fail++; $display("FAIL d5_load_use_stall3: got %b want 0", obs_stall[1]); end
    ins_nop();                       tick();
    n_tests++;
    if (obs_fa[1] !== 16'd4 || obs_cnt[1] !== 16'd2) begin
      n_fail++; $display("FAIL d5_load_use_fwd: got a=%0d cnt=%0d want a=4 cnt=2", obs_fa[1], obs_cnt[1]);
    end
  endtask

  task automatic test_d5_lw_sw();
    do_reset();
    ins_lw(5'd8);                    tick();
    ins_sw(5'd8, 5'd9);              tick();
    n_tests++;
    if (obs_stall[1] !== 1'b1) begin n_fail++; $display("FAIL d5_lw_sw_stall1: got %b want 1", obs_stall[1]); end
    tick();
    n_tests++;
    if (obs_stall[1] !== 1'b0) begin n_fail++; $display("FAIL d5_lw_sw_stall2: got %b want 0", obs_stall[1]); end
    ins_nop();                       tick();
    tick();
    n_tests++;
    if (obs_st[1] !== 16'd4) begin n_fail++; $display("FAIL d5_lw_sw_st_sel: got %0d want 4", obs_st[1]); end
  endtask

  // Store whose writer sits in the last tracked slot, plus the untracked WB case.
  task automatic test_store_window_edge();
    do_reset();
    ins_alu(5'd8, 5'd1, 5'd2);       tick();
    ins_nop();                       tick();
    ins_sw(5'd8, 5'd9);              tick();
    ins_nop();                       tick();
    n_tests++;
    if (obs_fb[0] !== 16'd3) begin n_fail++; $display("FAIL edge_d3_fwd_b: got %0d want 3", obs_fb[0]); end
    do_reset();
    ins_lw(5'd8);                    tick();
    ins_nop();                       tick();
    tick();
    tick();
    ins_sw(5'd8, 5'd9);              tick();
    n_tests++;
    if (obs_stall[1] !== 1'b0) begin n_fail++; $display("FAIL edge_d5_stall: got %b want 0", obs_stall[1]); end
    ins_nop();                       tick();
    n_tests++;
    if (obs_fb[1] !== 16'd5 || obs_fb[0] !== 16'd0) begin
      n_fail++; $display("FAIL edge_fwd_b: got d5=%0d d3=%0d want 5/0", obs_fb[1], obs_fb[0]);
    end
    tick();
    n_tests++;
    if (obs_st[1] !== 16'd0) begin n_fail++; $display("FAIL edge_d5_st_sel: got %0d want 0", obs_st[1]); end
  endtask

  task automatic test_random();
    logic st;
    do_reset();
    for (int c = 0; c < 600; c++) begin
      st = ($urandom_range(0, 3) == 0);
      id_valid     = ($urandom_range(0, 9) != 0);
      id_is_store  = st;
      id_reg_write = st ? 1'b0 : 1'($urandom_range(0, 1));
      id_mem2reg   = id_reg_write & ($urandom_range(0, 2) == 0);
      id_use_rs    = 1'($urandom_range(0, 1));
      id_use_rt    = st ? 1'b1 : 1'($urandom_range(0, 1));
      id_rs        = 5'($urandom_range(0, 4));
      id_rt        = 5'($urandom_range(0, 4));
      id_rd        = 5'($urandom_range(0, 4));
      rst_n        = ($urandom_range(0, 79) != 0);
      tick();
      for (int d = 0; d < 2; d++) begin
        n_tests++;
        if (obs_stall[d] !== exp_stall[d]) begin n_fail++; $display("FAIL rand_stall dut%0d cyc %0d: got %b want %b", d, c, obs_stall[d], exp_stall[d]); end
        n_tests++;
        if (obs_fa[d] !== exp_fa[d]) begin n_fail++; $display("FAIL rand_fwd_a dut%0d cyc %0d: got %0d want %0d", d, c, obs_fa[d], exp_fa[d]); end
        n_tests++;
        if (obs_fb[d] !== exp_fb[d]) begin n_fail++; $display("FAIL rand_fwd_b dut%0d cyc %0d: got %0d want %0d", d, c, obs_fb[d], exp_fb[d]); end
        n_tests++;
        if (obs_st[d] !== exp_st[d]) begin n_fail++; $display("FAIL rand_st_sel dut%0d cyc %0d: got %0d want %0d", d, c, obs_st[d], exp_st[d]); end
        n_tests++;
        if (obs_cnt[d] !== exp_cnt[d]) begin n_fail++; $display("FAIL rand_cnt dut%0d cyc %0d: got %0d want %0d", d, c, obs_cnt[d], exp_cnt[d]); end
      end
    end
    rst_n = 1'b1;
    ins_nop();
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    rst_n = 1'b0;
    ins_nop();
    test_reset();
    test_lw_sw_d3();
    test_load_use_d3();
    test_alu_fwd();
    test_youngest();
    test_reg_zero();
    test_reset_mid_stall();
    test_d5_load_use();
    test_d5_lw_sw();
    test_store_window_edge();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mem_fwd_hazard_unit.md
# mem_fwd_hazard_unit

Parametrised data-hazard unit for the pipelined CPU. It tracks in-flight register writers across a configurable number of post-decode stages and generates load-use stalls, EX-stage operand forward selects, and MEM-stage store-data forward selects, covering load→store forwarding for any load latency. It sits beside the ID stage, takes decoded fields from ID, and drives the operand muxes in EX and the store-data mux in MEM.

## Interface
- `REG_AW`, 5, register-index width.
- `DEPTH`, 3, number of tracked stages after ID (1 = EX, 2 = MEM, …, DEPTH = WB); legal values are 3 and up.
- `LOAD_LAT`, 1, stage index at whose end load data becomes forwardable is `1+LOAD_LAT`; range 1..DEPTH-2.
- `SELW`, derived, `$clog2(DEPTH+1)`.

Ports:
- `clk` in 1: clock, rising edge.
- `rst_n` in 1: reset, synchronous, active-low.
- `id_valid` in 1: ID holds a real instruction.
- `id_rs`, `id_rt` in REG_AW: source registers.
- `id_use_rs`, `id_use_rt` in 1: the source is read.
- `id_is_store` in 1: the instruction is a store; `rt` is store data.
- `id_reg_write` in 1: the instruction writes `id_rd`.
- `id_mem2reg` in 1: the instruction is a load.
- `id_rd` in REG_AW: destination register.
- `stall` out 1: combinational; hold PC/IF/ID and insert a bubble into EX.
- `fwd_a_sel`, `fwd_b_sel` out SELW: registered and EX-aligned. 0 selects the regfile value; k selects the result held in stage k.
- `st_fwd_sel` out SELW: registered and MEM-aligned store-data select. 0 selects the value carried down the pipe; k selects stage k.
- `stall_count` out 16: saturating count of stall cycles.

## Operation
- Scoreboard: DEPTH-1 entries `{valid, rd, is_load}` for stages 1..DEPTH-1. The entry at distance s is the writer s stages ahead of ID.
  - The regfile is write-before-read, so a stage-DEPTH writer is not tracked.
- Each cycle, entries shift s→s+1 and the last entry drops off.
- Stage 1 loads `{id_valid & id_reg_write & (id_rd!=0) & !stall, id_rd, id_mem2reg}`.
  - When `stall=1`, stage 1 loads a bubble (valid=0).
- Match rule: a source matches entry s if the entry is valid, `rd` equals the source register, and the use flag is set. Register 0 never matches. The smallest s (youngest writer) wins.
- Operand forwarding (rs always; rt when not a store):
  - Load match with s ≤ LOAD_LAT: stall.
  - Any other match: sel = s+1.
- Store data (rt when `id_is_store`):
  - Load match with s < LOAD_LAT: stall.
  - Match with s ≤ DEPTH-2: `st_fwd_sel` = s+2 and `fwd_b_sel` = 0.
  - Match with s = DEPTH-1: `fwd_b_sel` = DEPTH, captured into EX/MEM.
  - Stores never stall on ALU writers. Back-to-back lw→sw stalls only when LOAD_LAT ≥ 2.
- `stall` is the OR of all stall conditions, gated by `id_valid`.
- Select registers:
  - `fwd_a_sel`/`fwd_b_sel` capture the ID-computed selects at each edge. They load 0 when `stall` or `!id_valid`.
  - The store select passes through one extra register so it is MEM-aligned.
- `stall_count` increments each cycle `stall=1` and saturates at 16'hFFFF.

## Timing
- Reset (`rst_n=0` at an edge): all entries invalid; `fwd_a_sel`, `fwd_b_sel`, `st_fwd_sel`, `stall_count` = 0.
  - `stall` = 0 in the cycle after reset, because no entries are valid.
  - Reset dominates any concurrent stall or shift.
- `stall` is valid in the same cycle as the ID inputs. Its only dependence is on current state and ID inputs; it has no registered delay.
- A load-use stall lasts exactly LOAD_LAT−s+1 cycles for operands (LOAD_LAT−s for store data). Stall is re-evaluated each cycle as the writer advances.
- Forward selects appear one cycle after the ID cycle in which the instruction leaves ID (`!stall`). The store select appears two cycles after.
- Reset asserted mid-stall: stall drops after the reset edge and partial stall state is discarded.
- `id_valid=0` produces no stall and a bubble entry.

## Test plan
- DEPTH=3, LOAD_LAT=1: `lw $8` then `sw $8,0($9)` back-to-back → `stall` stays 0; `st_fwd_sel`=3 when the store is in MEM; `fwd_b_sel`=0.
- `lw $8` then `add $10,$8,$9` → `stall`=1 for exactly 1 cycle; `stall_count`=1; `fwd_a_sel`=3 when the add is in EX.
- `add $8` then `sub $11,$9,$8` → no stall; `fwd_b_sel`=2, `fwd_a_sel`=0.
- `add $8`, `or $8`, then `and $12,$8,$8` → youngest writer wins: `fwd_a_sel`=`fwd_b_sel`=2.
- Writer with rd=$0 followed by a reader of $0 → no stall, selects 0. Assert `rst_n=0` during a load-use stall → next cycle `stall`=0 and all outputs 0.
- DEPTH=5, LOAD_LAT=2: `lw $8` then a dependent `add` → stall 2 cycles, then `fwd_a_sel`=4. `lw $8` then `sw $8` → stall 1 cycle, then `st_fwd_sel`=4.
